// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that drains into a uart transmitter, one byte per idle period.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_wr,
  output logic                in_full,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic [7:0]          tx_data,
  output logic                tx_wr,
  input  logic                tx_busy
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_t;
  state_t r_state, w_next;
  logic [7:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_ptr, r_wr_ptr;
  logic [DEPTH_LOG2:0] r_count;
  logic r_overflow, r_tx_wr;
  logic [7:0] r_tx_data;
  logic w_push, w_pop;
  assign in_full  = r_count == (DEPTH_LOG2+1)'(DEPTH);
  assign w_push   = in_wr && !in_full;
  assign w_pop    = r_state == IDLE && r_count != '0 && !tx_busy;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_data  = r_tx_data;
  assign tx_wr    = r_tx_wr;
  // HOLD skips one cycle of tx_busy because the uart raises busy a cycle after wr
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_pop ? SEND : IDLE;
      SEND:    w_next = HOLD;
      HOLD:    w_next = WAIT;
      WAIT:    w_next = tx_busy ? WAIT : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_tx_wr    <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_tx_data <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
      if (in_wr && in_full) r_overflow <= 1'b1;
      r_tx_wr <= w_pop;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of the uart tx FIFO with a simple uart busy model.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst, in_wr, in_full, overflow, tx_wr, tx_busy;
  logic       model_en = 1'b0, busy_force = 1'b0;
  logic [7:0] in_data, tx_data;
  logic [4:0] count;
  int         busy_cnt = 0, cyc = 0;
  int         pulses = 0, wide = 0, busy_viol = 0, last_pc = -1000, min_gap = 1000;
  int         total = 0, bad = 0;
  logic       prev_wr = 1'b0;
  logic [7:0] q[$];

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_wr(in_wr), .in_full(in_full),
    .count(count), .overflow(overflow), .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // uart stand-in: busy rises the cycle after wr and lasts 20 cycles
  always @(posedge clk) begin
    if (tx_wr) busy_cnt <= 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = model_en ? busy_cnt != 0 : busy_force;

  always @(negedge clk) begin
    if (tx_wr) begin
      q.push_back(tx_data);
      pulses++;
      if (prev_wr) wide++;
      if (tx_busy) busy_viol++;
      if (cyc - last_pc < min_gap) min_gap = cyc - last_pc;
      last_pc = cyc;
    end
    prev_wr = tx_wr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input logic [7:0] first, input int n);
    chk({tag, "_n"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) chk(tag, q[i], int'(first) + i);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear;
    q.delete();
    pulses = 0; wide = 0; busy_viol = 0; min_gap = 1000; last_pc = -1000;
  endtask

  task automatic push(input logic [7:0] d);
    in_data = d; in_wr = 1'b1;
    tick;
  endtask

  initial begin
    rst = 1'b1; in_wr = 1'b1; in_data = 8'h55;
    tick; tick;
    chk("rst_count", count, 0);
    chk("rst_full", in_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_txwr", tx_wr, 0);
    chk("rst_txdata", tx_data, 8'h00);
    rst = 1'b0; in_wr = 1'b0;
    tick;
    chk("rst_empty", count, 0);

    mon_clear;
    push(8'hA5); in_wr = 1'b0;
    chk("one_count1", count, 1);
    chk("one_nowr", tx_wr, 0);
    tick;
    chk("one_wr", tx_wr, 1);
    chk("one_data", tx_data, 8'hA5);
    chk("one_count0", count, 0);
    tick;
    chk("one_wr_low", tx_wr, 0);
    chk("one_data_hold", tx_data, 8'hA5);
    repeat (6) tick;
    chk("one_pulses", pulses, 1);
    chk("one_wide", wide, 0);
    repeat (25) tick;

    mon_clear;
    model_en = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); in_wr = 1'b0;
    repeat (100) tick;
    chk_seq("pace", 8'h01, 3);
    chk("pace_wide", wide, 0);
    chk("pace_busy", busy_viol, 0);
    chk("pace_gap", min_gap >= 4, 1);

    model_en = 1'b0; busy_force = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      if (i == 15) begin
        chk("full_count", count, 16);
        chk("full_flag", in_full, 1);
        chk("full_noovf", overflow, 0);
      end
    end
    in_wr = 1'b0;
    chk("ovf_count", count, 16);
    chk("ovf_full", in_full, 1);
    chk("ovf_flag", overflow, 1);
    mon_clear;
    busy_force = 1'b0;
    repeat (80) tick;
    chk_seq("full_drain", 8'h00, 16);
    chk("full_drain_count", count, 0);
    chk("full_drain_nfull", in_full, 0);

    busy_force = 1'b1;
    push(8'h30); push(8'h31); push(8'h32); in_wr = 1'b0;
    chk("sim_pre", count, 3);
    mon_clear;
    busy_force = 1'b0;
    push(8'h33); in_wr = 1'b0;
    chk("sim_count", count, 3);
    chk("sim_wr", tx_wr, 1);
    chk("sim_data", tx_data, 8'h30);
    repeat (30) tick;
    chk_seq("sim_drain", 8'h30, 4);
    chk("sim_count0", count, 0);

    busy_force = 1'b1;
    mon_clear;
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    in_wr = 1'b0;
    chk("wrap_full", in_full, 1);
    busy_force = 1'b0;
    repeat (80) tick;
    chk_seq("wrap", 8'h40, 16);

    repeat (25) tick;
    mon_clear;
    model_en = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    in_wr = 1'b0;
    repeat (5) tick;
    chk("mid_count", count, 4);
    chk("mid_busy", tx_busy, 1);
    chk("mid_ovf_sticky", overflow, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_wr", tx_wr, 0);
    model_en = 1'b0; busy_force = 1'b0;
    mon_clear;
    push(8'h77); in_wr = 1'b0;
    chk("post_count", count, 1);
    chk("post_nowr", tx_wr, 0);
    tick;
    chk("post_wr", tx_wr, 1);
    chk("post_data", tx_data, 8'h77);
    repeat (20) tick;
    chk_seq("post", 8'h77, 1);
    chk("post_count0", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
